// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and defaults for the LED blink-code sequencer.
package led_seq_pkg;
    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;
    localparam int DEF_N_REQ      = 4;
    localparam int DEF_PRESCALE_W = 22;
    localparam int DEF_CODE_W     = 4;
    localparam int DEF_GAP_TICKS  = 4;
    localparam int HB_PERIOD      = 8;
endpackage

// File: rtl/led_code_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first set request at or after ptr.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    // Scan from the farthest offset down so the nearest request to ptr wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (en && req[(int'(ptr) + k) % N]) begin
                grant                        = '0;
                grant[(int'(ptr) + k) % N]   = 1'b1;
                idx                          = IW'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/led_code_sequencer.sv
// led_code_sequencer: round-robin shares one LED among requesters flashing k-pulse blink codes.
// Define LED_HEARTBEAT_EN for a 1-in-8-tick heartbeat while idle with no pending request.
module led_code_sequencer
    import led_seq_pkg::*;
#(
    parameter int N_REQ      = DEF_N_REQ,
    parameter int PRESCALE_W = DEF_PRESCALE_W,
    parameter int CODE_W     = DEF_CODE_W,
    parameter int GAP_TICKS  = DEF_GAP_TICKS
) (
    input  logic                                         clk,
    input  logic                                         rstn,
    input  logic [N_REQ-1:0]                             req,
    input  logic [N_REQ*CODE_W-1:0]                      code,
    output logic [N_REQ-1:0]                             ack,
    output logic                                         busy,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] owner,
    output logic                                         LED
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;

    state_t              state, state_d;
    logic [PRESCALE_W-1:0] presc, presc_d;
    logic [CODE_W-1:0]   rem, rem_d;
    logic [GW-1:0]       gap_cnt, gap_d;
    logic [OW-1:0]       ptr, ptr_d, owner_d, gidx;
    logic [N_REQ-1:0]    grant, ack_d;
    logic [CODE_W-1:0]   gcode;
    logic                led_d, tick;

    rr_arbiter #(.N(N_REQ), .IW(OW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .en    (state == IDLE),
        .grant (grant),
        .idx   (gidx)
    );

    assign tick  = &presc;
    assign gcode = code[gidx*CODE_W +: CODE_W];
    assign busy  = state != IDLE;

`ifdef LED_HEARTBEAT_EN
    logic [$clog2(HB_PERIOD)-1:0] hb_cnt, hb_d;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) hb_cnt <= '0;
        else       hb_cnt <= hb_d;
    end
    always_comb begin
        hb_d = '0;
        if (state == IDLE && !(|grant)) hb_d = tick ? hb_cnt + 1'b1 : hb_cnt;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            presc   <= '0;
            rem     <= '0;
            gap_cnt <= '0;
            ptr     <= '0;
            owner   <= '0;
            ack     <= '0;
            LED     <= 1'b0;
        end else begin
            state   <= state_d;
            presc   <= presc_d;
            rem     <= rem_d;
            gap_cnt <= gap_d;
            ptr     <= ptr_d;
            owner   <= owner_d;
            ack     <= ack_d;
            LED     <= led_d;
        end
    end

    always_comb begin
        state_d = state;
        presc_d = presc + 1'b1;
        rem_d   = rem;
        gap_d   = gap_cnt;
        ptr_d   = ptr;
        owner_d = owner;
        ack_d   = '0;
        led_d   = 1'b0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    // Restart the prescaler so the first phase is a full tick long.
                    ack_d   = grant;
                    owner_d = gidx;
                    ptr_d   = (int'(gidx) == N_REQ - 1) ? '0 : gidx + 1'b1;
                    presc_d = '0;
                    rem_d   = gcode;
                    gap_d   = '0;
                    state_d = (gcode != '0) ? ON : GAP;
                    led_d   = gcode != '0;
                end
`ifdef LED_HEARTBEAT_EN
                else led_d = hb_cnt == '0;
`endif
            end
            ON: begin
                led_d = !tick;
                if (tick) begin
                    state_d = OFF;
                    rem_d   = rem - 1'b1;
                end
            end
            OFF: begin
                if (tick) begin
                    state_d = (rem != '0) ? ON : GAP;
                    led_d   = rem != '0;
                    gap_d   = '0;
                end
            end
            GAP: begin
                if (tick) begin
                    gap_d   = (gap_cnt == GW'(GAP_TICKS - 1)) ? '0 : gap_cnt + 1'b1;
                    state_d = (gap_cnt == GW'(GAP_TICKS - 1)) ? IDLE : GAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
